// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  vid_pkg
//  Shared axis phase encoding and default 640x480@60 timing constants.
//  Revision: 1.0
// ============================================================================
package vid_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } vid_phase_e;

    localparam int c_CW = 12;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;

    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

endpackage
`default_nettype wire

// File: rtl/vid_axis_ctr.sv
`default_nettype none
// ============================================================================
//  vid_axis_ctr
//  One timing axis: position counter, ACTIVE/FRONT/SYNC/BACK phase FSM, wrap.
//  Revision: 1.0
// ============================================================================
module vid_axis_ctr
    import vid_pkg::*;
#(
    parameter int ACTIVE = c_H_ACTIVE,
    parameter int FP     = c_H_FP,
    parameter int SYNC   = c_H_SYNC,
    parameter int BP     = c_H_BP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_step,
    output logic [c_CW-1:0] o_count,
    output vid_phase_e      o_phase_nxt,
    output logic            o_wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [c_CW-1:0] c_END_ACT  = c_CW'(ACTIVE - 1);
    localparam logic [c_CW-1:0] c_END_FP   = c_CW'(ACTIVE + FP - 1);
    localparam logic [c_CW-1:0] c_END_SYNC = c_CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [c_CW-1:0] c_END_BACK = c_CW'(TOTAL - 1);

    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    vid_phase_e      r_phase;
    vid_phase_e      w_phase_nxt;

    assign o_wrap      = (r_count == c_END_BACK);
    assign o_count     = r_count;
    assign o_phase_nxt = w_phase_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= PH_ACTIVE;
        end else begin
            r_count <= w_count_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Phase advances on the step that leaves the last index of its region,
    // so phase and count always describe the same position.
    always_comb begin
        w_count_nxt = r_count;
        w_phase_nxt = r_phase;
        if (i_clear) begin
            w_count_nxt = '0;
            w_phase_nxt = PH_ACTIVE;
        end else if (i_step) begin
            w_count_nxt = o_wrap ? '0 : r_count + 1'b1;
            case (r_phase)
                PH_ACTIVE: if (r_count == c_END_ACT)  w_phase_nxt = PH_FRONT;
                PH_FRONT:  if (r_count == c_END_FP)   w_phase_nxt = PH_SYNC;
                PH_SYNC:   if (r_count == c_END_SYNC) w_phase_nxt = PH_BACK;
                PH_BACK:   if (r_count == c_END_BACK) w_phase_nxt = PH_ACTIVE;
                default:   w_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vid_timing.sv
`default_nettype none
// ============================================================================
//  vid_timing
//  Raster timing generator: pixel strobe, h/v counters, blanking and sync.
//  Revision: 1.0
// ============================================================================
module vid_timing
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int PIX_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            enable,
    output logic            hsync,
    output logic            vsync,
    output logic            hblank,
    output logic            vblank,
    output logic [c_CW-1:0] hcount,
    output logic [c_CW-1:0] vcount,
    output logic            frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] c_DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic       c_SYNC_ON  = (SYNC_POL != 0);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            H_TOTAL > 4096 || V_TOTAL > 4096 ||
            PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_params
            $error("vid_timing: illegal timing parameters");
        end
    endgenerate

    logic [3:0]  r_div;
    logic        r_enable;
    logic        r_frame_start;
    logic        r_hblank;
    logic        r_vblank;
    logic        r_hsync;
    logic        r_vsync;
    logic        w_tick;
    logic        w_idle;
    logic        w_h_wrap;
    logic        w_v_wrap;
    vid_phase_e  w_h_phase_nxt;
    vid_phase_e  w_v_phase_nxt;

    assign w_idle = ~run;
    assign w_tick = run && (r_div == c_DIV_LAST);

    // Counters step on the clk that carries a strobe, so between strobes they
    // already hold the pixel the next strobe will present.
    vid_axis_ctr #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_idle),
        .i_step      (r_enable),
        .o_count     (hcount),
        .o_phase_nxt (w_h_phase_nxt),
        .o_wrap      (w_h_wrap)
    );

    vid_axis_ctr #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_idle),
        .i_step      (r_enable & w_h_wrap),
        .o_count     (vcount),
        .o_phase_nxt (w_v_phase_nxt),
        .o_wrap      (w_v_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_div         <= '0;
            r_enable      <= 1'b0;
            r_frame_start <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_hsync       <= ~c_SYNC_ON;
            r_vsync       <= ~c_SYNC_ON;
        end else begin
            r_div         <= w_tick ? '0 : r_div + 1'b1;
            r_enable      <= w_tick;
            // With PIX_DIV = 1 the counters step on the same edge as the
            // new strobe, so the origin is reached through a double wrap.
            r_frame_start <= w_tick && (r_enable ? (w_h_wrap && w_v_wrap)
                                                 : (hcount == '0 && vcount == '0));
            r_hblank      <= (w_h_phase_nxt != PH_ACTIVE);
            r_vblank      <= (w_v_phase_nxt != PH_ACTIVE);
            r_hsync       <= (w_h_phase_nxt == PH_SYNC) ? c_SYNC_ON : ~c_SYNC_ON;
            r_vsync       <= (w_v_phase_nxt == PH_SYNC) ? c_SYNC_ON : ~c_SYNC_ON;
        end
    end

    assign enable      = r_enable;
    assign frame_start = r_frame_start;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule
`default_nettype wire

// File: doc/vid_timing.md
VID_TIMING -- requirements
Module: vid_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch, in lines.
REQ-005 Parameter PIX_DIV, default 4, clk cycles per pixel (1..16).
REQ-006 Parameter SYNC_POL, default 0, asserted level of hsync/vsync (0 = active-low).
REQ-007 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1, synchronous active-high reset.
REQ-009 Port run, input, 1, level; high = generate timing, low = idle.
REQ-010 Port enable, output, 1, one-clk pixel strobe; the downstream video stage advances one pixel per strobe.
REQ-011 Port hsync / vsync, output, 1 each, sync pulses at SYNC_POL level.
REQ-012 Port hblank / vblank, output, 1 each, high outside the active region of the axis.
REQ-013 Port hcount / vcount, output, 12 each, current pixel / line index.
REQ-014 Port frame_start, output, 1, one-clk pulse on the strobe of pixel (0,0).

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL (same form) shall each be <= 4096; every porch/sync parameter shall be >= 1 (elaboration check).
REQ-016 Divider: div counts 0..PIX_DIV-1 and wraps; enable = 1 exactly when div == PIX_DIV-1 and run = 1; PIX_DIV = 1 gives enable high every clk.
REQ-017 hcount shall advance only on clks with enable = 1, wrapping H_TOTAL-1 -> 0.
REQ-018 vcount shall advance only on clks where enable = 1 and hcount == H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
REQ-019 Each axis shall run a phase FSM ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE; a transition occurs when the axis count reaches the last index of the current phase.
REQ-020 hblank = (h phase != ACTIVE); hsync asserted iff h phase == SYNC; likewise vblank/vsync from the v phase.
REQ-021 hcount, vcount, the phase FSMs and all outputs shall be registers updated in the same clk, so all outputs are mutually consistent: no combinational path from counters to outputs and no skew between them.
REQ-022 Default-parameter timing: hsync asserted for hcount 656..751; vsync asserted for vcount 490..491.
REQ-023 frame_start = 1 only on the enable clk on which (hcount, vcount) == (0, 0) is presented.
REQ-024 Idle (run = 0): div = 0, hcount = vcount = 0, both FSMs in ACTIVE, enable = 0, frame_start = 0, hblank = vblank = 1, hsync/vsync deasserted.
REQ-025 run 0 -> 1: the first enable occurs PIX_DIV clks later and coincides with frame_start at pixel (0,0).
REQ-026 run 1 -> 0 mid-frame: enter idle values on the next clk; a later restart begins again at (0,0).
REQ-027 Simultaneous horizontal and vertical wrap (last pixel of last line) shall return to (0,0) with both FSMs in ACTIVE and frame_start = 1 on that strobe.

Reset
REQ-028 reset = 1 shall force the REQ-024 idle values on the next clk edge, overriding run.
REQ-029 Reset asserted mid-frame shall abort the frame; after release, timing restarts at (0,0) per REQ-025 if run = 1.

Structure
REQ-030 Shared package vid_pkg shall hold the phase enum (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK) and the default 640x480 timing constants.
REQ-031 A sub-module vid_axis_ctr (count, phase FSM, wrap flag; parameterised by active/fp/sync/bp) shall be instantiated twice, once for h and once for v.

Verification
Bench parameters: H = 8/2/3/1 (H_TOTAL 14); V = 4/1/2/1 (V_TOTAL 8); PIX_DIV = 2; SYNC_POL = 1.
REQ-032 Pixel strobe: reset, then run = 1 -> enable on clk 2, 4, 6, ...; first strobe shows hcount = 0, vcount = 0, frame_start = 1.
REQ-033 Horizontal sequence: over one line -> hblank = 0 for hcount 0..7, = 1 for 8..13; hsync = 1 for hcount 10..12 only; hcount wraps 13 -> 0.
REQ-034 Vertical sequence: one full frame -> vblank = 1 for vcount 4..7; vsync = 1 for vcount 5..6; exactly one frame_start per 112 strobes.
REQ-035 Frame wrap: at hcount = 13, vcount = 7, next strobe -> (0,0) with hblank = vblank = 0 and frame_start = 1.
REQ-036 Abort/restart: drop run at hcount = 5, vcount = 2 -> next clk shows idle values; raise run -> first strobe 2 clks later at (0,0); repeat the test using reset instead of run, with the same result.
